// File: rtl/digit_serial_adder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | digit_serial_adder_pkg : state encoding for digit_serial_adder    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package digit_serial_adder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/digit_serial_adder_digit_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | digit_adder : combinational DIGIT-bit ripple adder                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    always_comb begin
        {co, s}  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
        // The top sum bit is x^y^carry_in, so the carry into it falls out directly.
        c_msb_in = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
    end

endmodule
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | digit_serial_adder : WIDTH-bit adder, DIGIT bits per clock with   |
// | valid/ready handshakes. Optional DIGIT_SERIAL_ADDER_SUB_EN adds   |
// | the sub port. Rev 1.0                                            |
// +------------------------------------------------------------------+
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

    generate
        if ((WIDTH % DIGIT) != 0 || NDIG < 1) begin : g_param_check
            $error("WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic             w_sub;
    logic [DIGIT-1:0] w_s;
    logic             w_co, w_c_msb;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .ci       (carry_q),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_c_msb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + !cin, so invert once at load time.
                    a_d     = a;
                    b_d     = w_sub ? ~b : b;
                    carry_d = cin ^ w_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
                carry_d = w_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    cout_d  = w_co;
                    ovf_d   = w_co ^ w_c_msb;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_digit_serial_adder : randomized bench with arithmetic model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_digit_serial_adder;

    localparam int W    = 16;
    localparam int D    = 4;
    localparam int NDIG = W / D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, sub, cout, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: whole-word arithmetic, overflow from operand/result signs.
    task automatic model(input logic [W-1:0] ma, mb, input logic mc, ms,
                         output logic [W-1:0] es, output logic ec, eo);
        logic [W:0]   t;
        logic [W-1:0] bb;
        bb = ms ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, bb} + (W+1)'(ms ? !mc : mc);
        es = t[W-1:0];
        ec = t[W];
        eo = (ma[W-1] == bb[W-1]) && (es[W-1] != ma[W-1]);
    endtask

    // Drives one operation and waits (bounded) for its result.
    task automatic do_op(input logic [W-1:0] ta, tb_, input logic tc, ts,
                         output logic [W-1:0] rs, output logic rc, ro,
                         output int lat, output bit to);
        lat = 0;
        to  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) to = 1'b1;
        rs = sum; rc = cout; ro = ovf;
    endtask

    task automatic check_op(input string nm, input logic [W-1:0] ta, tb_,
                            input logic tc, ts, input bit chk_lat);
        logic [W-1:0] rs, es;
        logic rc, ro, ec, eo;
        int lat;
        bit to;
        model(ta, tb_, tc, ts, es, ec, eo);
        do_op(ta, tb_, tc, ts, rs, rc, ro, lat, to);
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid never rose", nm);
        end
        n_tests++;
        if ({rs, rc, ro} !== {es, ec, eo}) begin
            n_fail++;
            $display("FAIL %s a=%h b=%h cin=%b sub=%b: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     nm, ta, tb_, tc, ts, rs, rc, ro, es, ec, eo);
        end
        if (chk_lat) begin
            n_tests++;
            if (lat !== NDIG) begin
                n_fail++;
                $display("FAIL %s latency got=%0d want=%0d", nm, lat, NDIG);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        check_op("dir_0p1",      16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);
        check_op("dir_wrap",     16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        check_op("dir_overflow", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        check_op("dir_negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic ts;
        for (int i = 0; i < 40; i++) begin
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
            ts = 1'($urandom % 2);
`else
            ts = 1'b0;
`endif
            check_op("random", W'($urandom), W'($urandom), 1'($urandom % 2), ts, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            check_op("b2b", W'($urandom), W'($urandom), 1'($urandom % 2), 1'b0, 1'b1);
            @(posedge clk); #1;
            n_tests++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] rs, es;
        logic rc, ro, ec, eo;
        int lat;
        bit to;
        out_ready = 1'b0;
        model(16'h1357, 16'h9ACE, 1'b1, 1'b0, es, ec, eo);
        do_op(16'h1357, 16'h9ACE, 1'b1, 1'b0, rs, rc, ro, lat, to);
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            n_tests++;
            if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, es, ec, eo}) begin
                n_fail++;
                $display("FAIL backpressure_hold cyc=%0d got vld=%b rdy=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                         i, out_valid, in_ready, sum, cout, ovf, es, ec, eo);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        check_op("after_backpressure", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        a = 16'hABCD; b = 16'h4321; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, sum, in_ready} !== {1'b0, {W{1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid got vld=%b sum=%h rdy=%b want 0 0000 1", out_valid, sum, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        check_op("after_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        check_op("sub_5m3", 16'h0005, 16'h0003, 1'b0, 1'b1, 1'b1);
        check_op("sub_3m5", 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1);
        check_op("sub_minovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
